// File: rtl/comp_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Package     : comp_pkg                                               |
// | Description : Shared types and constants for the complex multiply /  |
// |               accumulate datapath.                                   |
// |               acc_state_t - frame accumulator control states         |
// |               COMP_PROD_W - width of one complex-product component   |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
package comp_pkg;

   localparam int COMP_PROD_W = 17;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      ACC  = 1'b1
   } acc_state_t;

endpackage : comp_pkg
`default_nettype wire

// File: rtl/comp_acc_lane.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : comp_acc_lane                                          |
// | Description : One component (real or imaginary) of the frame        |
// |               accumulator: a signed running sum and the output       |
// |               register that captures a finished frame sum.           |
// | Ports       : clk, rst      - clock, async active-high reset         |
// |               i_clr         - start a new sum (seeded by i_data when |
// |                               i_add_en is also high, else zero)      |
// |               i_add_en      - add sign-extended i_data to the sum    |
// |               i_load_out    - capture (sum + i_data) in the output   |
// |               i_data        - signed IN_W sample                     |
// |               o_data        - signed ACC_W held frame sum            |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module comp_acc_lane
   import comp_pkg::*;
#(
   parameter int IN_W  = COMP_PROD_W,
   parameter int ACC_W = COMP_PROD_W + 4
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    i_clr,
   input  logic                    i_add_en,
   input  logic                    i_load_out,
   input  logic signed [IN_W-1:0]  i_data,
   output logic signed [ACC_W-1:0] o_data
);

   logic signed [ACC_W-1:0] r_acc;
   logic signed [ACC_W-1:0] r_out;
   logic signed [ACC_W-1:0] w_ext;
   logic signed [ACC_W-1:0] w_sum;

   assign w_ext = {{(ACC_W-IN_W){i_data[IN_W-1]}}, i_data};

   // The output register always captures sum-including-this-sample, so the
   // control can load the final result while independently clearing the
   // accumulator for a frame that starts on the same edge.
   assign w_sum = r_acc + w_ext;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_acc <= '0;
      end else if (i_clr) begin
         r_acc <= i_add_en ? w_ext : '0;
      end else if (i_add_en) begin
         r_acc <= w_sum;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_out <= '0;
      end else if (i_load_out) begin
         r_out <= w_sum;
      end
   end

   assign o_data = r_out;

endmodule : comp_acc_lane
`default_nettype wire

// File: rtl/comp_acc.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : comp_acc                                               |
// | Description : Complex frame accumulator. Sums N_LEN consecutive      |
// |               complex products into full-precision totals and        |
// |               presents each frame result through a one-entry         |
// |               valid/ready output register.                           |
// | Ports       : clk, rst          - clock, async active-high reset     |
// |               i_start           - begin / restart a frame            |
// |               i_valid, i_r, i_i - one signed product per pulse       |
// |               o_valid, o_ready  - output handshake                   |
// |               o_r, o_i          - signed ACC_W frame sums            |
// |               o_busy            - frame in progress                  |
// |               o_ovr             - sticky: completed frame dropped    |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module comp_acc
   import comp_pkg::*;
#(
   parameter int N_LEN = 16,
   parameter int IN_W  = COMP_PROD_W
) (
   input  logic                                      clk,
   input  logic                                      rst,
   input  logic                                      i_start,
   input  logic                                      i_valid,
   input  logic signed [IN_W-1:0]                    i_r,
   input  logic signed [IN_W-1:0]                    i_i,
   output logic                                      o_valid,
   input  logic                                      o_ready,
   output logic signed [IN_W+$clog2(N_LEN)-1:0]      o_r,
   output logic signed [IN_W+$clog2(N_LEN)-1:0]      o_i,
   output logic                                      o_busy,
   output logic                                      o_ovr
);

   localparam int ACC_W = IN_W + $clog2(N_LEN);
   localparam int CNT_W = $clog2(N_LEN) + 1;
   localparam logic [CNT_W-1:0] C_LAST = CNT_W'(N_LEN - 1);

   acc_state_t       r_state, w_state_nxt;
   logic [CNT_W-1:0] r_cnt,   w_cnt_nxt;
   logic             r_valid;
   logic             r_ovr;

   logic w_clr;
   logic w_add_en;
   logic w_load;
   logic w_set_ovr;
   logic w_take;
   logic w_done;

   // Output register is free if empty or being drained on this same edge.
   assign w_take = r_valid & o_ready;
   assign w_done = (r_state == ACC) & i_valid & (r_cnt == C_LAST);

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_clr       = 1'b0;
      w_add_en    = 1'b0;
      w_load      = 1'b0;
      w_set_ovr   = 1'b0;

      case (r_state)
         IDLE: begin
            if (i_start) begin
               w_state_nxt = ACC;
               w_clr       = 1'b1;
               w_add_en    = i_valid;
               w_cnt_nxt   = i_valid ? CNT_W'(1) : '0;
            end
         end

         ACC: begin
            if (w_done) begin
               if (!r_valid || w_take) begin
                  w_load = 1'b1;
               end else begin
                  w_set_ovr = 1'b1;
               end
               // The completing sample belongs to the finished frame, so a
               // coincident start opens an empty frame.
               if (i_start) begin
                  w_state_nxt = ACC;
                  w_clr       = 1'b1;
                  w_cnt_nxt   = '0;
               end else begin
                  w_state_nxt = IDLE;
                  w_cnt_nxt   = '0;
               end
            end else if (i_start) begin
               w_clr     = 1'b1;
               w_add_en  = i_valid;
               w_cnt_nxt = i_valid ? CNT_W'(1) : '0;
            end else if (i_valid) begin
               w_add_en  = 1'b1;
               w_cnt_nxt = r_cnt + CNT_W'(1);
            end
         end

         default: begin
            w_state_nxt = IDLE;
            w_cnt_nxt   = '0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
         r_cnt   <= '0;
         r_valid <= 1'b0;
         r_ovr   <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         if (w_load) begin
            r_valid <= 1'b1;
         end else if (w_take) begin
            r_valid <= 1'b0;
         end
         if (w_set_ovr) begin
            r_ovr <= 1'b1;
         end
      end
   end

   comp_acc_lane #(
      .IN_W  (IN_W),
      .ACC_W (ACC_W)
   ) u_lane_r (
      .clk        (clk),
      .rst        (rst),
      .i_clr      (w_clr),
      .i_add_en   (w_add_en),
      .i_load_out (w_load),
      .i_data     (i_r),
      .o_data     (o_r)
   );

   comp_acc_lane #(
      .IN_W  (IN_W),
      .ACC_W (ACC_W)
   ) u_lane_i (
      .clk        (clk),
      .rst        (rst),
      .i_clr      (w_clr),
      .i_add_en   (w_add_en),
      .i_load_out (w_load),
      .i_data     (i_i),
      .o_data     (o_i)
   );

   assign o_valid = r_valid;
   assign o_busy  = (r_state == ACC);
   assign o_ovr   = r_ovr;

endmodule : comp_acc
`default_nettype wire

// File: tb/tb_comp_acc.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_comp_acc                                            |
// | Description : Self-checking bench for comp_acc with N_LEN=4,         |
// |               IN_W=17 (ACC_W=19). Table of directed vectors plus     |
// |               hand-written multi-cycle sequences.                    |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module tb_comp_acc;

   localparam int N_LEN = 4;
   localparam int IN_W  = 17;
   localparam int ACC_W = IN_W + $clog2(N_LEN);

   logic                    clk;
   logic                    rst;
   logic                    i_start;
   logic                    i_valid;
   logic signed [IN_W-1:0]  i_r;
   logic signed [IN_W-1:0]  i_i;
   logic                    o_valid;
   logic                    o_ready;
   logic signed [ACC_W-1:0] o_r;
   logic signed [ACC_W-1:0] o_i;
   logic                    o_busy;
   logic                    o_ovr;

   int n_total;
   int n_bad;

   comp_acc #(
      .N_LEN (N_LEN),
      .IN_W  (IN_W)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .i_start (i_start),
      .i_valid (i_valid),
      .i_r     (i_r),
      .i_i     (i_i),
      .o_valid (o_valid),
      .o_ready (o_ready),
      .o_r     (o_r),
      .o_i     (o_i),
      .o_busy  (o_busy),
      .o_ovr   (o_ovr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        start;
      logic        valid;
      int          r;
      int          i;
      logic        ready;
      logic        e_valid;
      int          e_r;
      int          e_i;
      logic        e_busy;
      logic        e_ovr;
   } vec_t;

   vec_t vecs[19];

   task automatic chk(input string name, input int act, input int exp);
      n_total++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Apply one cycle of inputs, then look at the outputs 1ns after the edge.
   task automatic step(input logic s, input logic v, input int r, input int i, input logic rdy);
      i_start = s;
      i_valid = v;
      i_r     = IN_W'(r);
      i_i     = IN_W'(i);
      o_ready = rdy;
      @(posedge clk);
      #1;
      i_start = 1'b0;
      i_valid = 1'b0;
   endtask

   task automatic chk_out(input string name, input logic v, input int r, input int i,
                          input logic busy, input logic ovr);
      chk({name, ".valid"}, int'(o_valid), int'(v));
      chk({name, ".busy"},  int'(o_busy),  int'(busy));
      chk({name, ".ovr"},   int'(o_ovr),   int'(ovr));
      if (v) begin
         chk({name, ".r"}, int'(o_r), r);
         chk({name, ".i"}, int'(o_i), i);
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   initial begin
      int sr, si, vr, vi, k;
      n_total = 0;
      n_bad   = 0;
      rst = 1'b1; i_start = 1'b0; i_valid = 1'b0; i_r = '0; i_i = '0; o_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("reset.valid", int'(o_valid), 0);
      chk("reset.r",     int'(o_r), 0);
      chk("reset.i",     int'(o_i), 0);
      chk("reset.busy",  int'(o_busy), 0);
      chk("reset.ovr",   int'(o_ovr), 0);
      rst = 1'b0;
      @(posedge clk);
      #1;

      // ---------------- table-driven vectors ----------------
      //           start valid   r       i     rdy  ev  er       ei      busy ovr
      vecs[0]  = '{1, 1,   100,    -50,  1, 0, 0,       0,      1, 0};
      vecs[1]  = '{0, 1,   100,    -50,  1, 0, 0,       0,      1, 0};
      vecs[2]  = '{0, 1,   100,    -50,  1, 0, 0,       0,      1, 0};
      vecs[3]  = '{0, 1,   100,    -50,  1, 1, 400,     -200,   0, 0};
      vecs[4]  = '{0, 0,   0,      0,    1, 0, 0,       0,      0, 0};
      vecs[5]  = '{1, 1,   -65536, 65535,1, 0, 0,       0,      1, 0};
      vecs[6]  = '{0, 1,   -65536, 65535,1, 0, 0,       0,      1, 0};
      vecs[7]  = '{0, 1,   -65536, 65535,1, 0, 0,       0,      1, 0};
      vecs[8]  = '{0, 1,   -65536, 65535,1, 1, -262144, 262140, 0, 0};
      vecs[9]  = '{0, 0,   0,      0,    1, 0, 0,       0,      0, 0};
      vecs[10] = '{1, 1,   1,      1,    1, 0, 0,       0,      1, 0};
      vecs[11] = '{0, 1,   1,      1,    1, 0, 0,       0,      1, 0};
      vecs[12] = '{0, 1,   1,      1,    1, 0, 0,       0,      1, 0};
      vecs[13] = '{0, 1,   1,      1,    1, 1, 4,       4,      0, 0};
      vecs[14] = '{1, 1,   2,      -3,   1, 0, 0,       0,      1, 0};
      vecs[15] = '{0, 1,   2,      -3,   1, 0, 0,       0,      1, 0};
      vecs[16] = '{0, 1,   2,      -3,   1, 0, 0,       0,      1, 0};
      vecs[17] = '{0, 1,   2,      -3,   1, 1, 8,       -12,    0, 0};
      vecs[18] = '{0, 0,   0,      0,    1, 0, 0,       0,      0, 0};
      for (int n = 0; n < 19; n++) begin
         step(vecs[n].start, vecs[n].valid, vecs[n].r, vecs[n].i, vecs[n].ready);
         chk_out($sformatf("vec%0d", n), vecs[n].e_valid, vecs[n].e_r, vecs[n].e_i,
                 vecs[n].e_busy, vecs[n].e_ovr);
      end

      // ---------------- backpressure / overrun ----------------
      step(1, 1, 1, 1, 0);
      repeat (3) step(0, 1, 1, 1, 0);
      chk_out("bp.A", 1, 4, 4, 0, 0);
      step(1, 1, 5, 5, 0);
      repeat (3) step(0, 1, 5, 5, 0);
      chk_out("bp.B_dropped", 1, 4, 4, 0, 1);
      step(0, 0, 0, 0, 1);
      chk_out("bp.drained", 0, 0, 0, 0, 1);
      step(0, 0, 0, 0, 1);
      chk("bp.ovr_sticky", int'(o_ovr), 1);
      do_reset();
      chk_out("bp.reset", 0, 0, 0, 0, 0);
      chk("bp.reset_r", int'(o_r), 0);

      // ---------------- restart mid-frame ----------------
      step(1, 1, 10, 10, 1);
      step(0, 1, 10, 10, 1);
      step(1, 1, 1, 2, 1);
      step(0, 1, 1, 2, 1);
      step(0, 1, 1, 2, 1);
      chk_out("restart.pending", 0, 0, 0, 1, 0);
      step(0, 1, 1, 2, 1);
      chk_out("restart.result", 1, 4, 8, 0, 0);
      step(0, 0, 0, 0, 1);

      // ---------------- gapped input vs reference sum ----------------
      for (int f = 0; f < 3; f++) begin
         sr = 0; si = 0; k = 0;
         vr = int'($urandom_range(0, 131071)) - 65536;
         vi = int'($urandom_range(0, 131071)) - 65536;
         step(1, 1, vr, vi, 1);
         sr += vr; si += vi; k = 1;
         while (k < N_LEN) begin
            repeat ($urandom_range(0, 3)) step(0, 0, 7, 7, 1);
            vr = int'($urandom_range(0, 131071)) - 65536;
            vi = int'($urandom_range(0, 131071)) - 65536;
            step(0, 1, vr, vi, 1);
            sr += vr; si += vi; k++;
         end
         chk_out($sformatf("gap%0d", f), 1, sr, si, 0, 0);
         step(0, 0, 0, 0, 1);
      end

      // ---------------- reset mid-frame and mid-hold ----------------
      step(1, 1, 50, 50, 0);
      step(0, 1, 50, 50, 0);
      rst = 1'b1;
      #2;
      chk_out("rst.midframe", 0, 0, 0, 0, 0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      step(1, 1, 3, 3, 0);
      repeat (3) step(0, 1, 3, 3, 0);
      chk_out("rst.fresh", 1, 12, 12, 0, 0);
      rst = 1'b1;
      #2;
      chk("rst.hold.valid", int'(o_valid), 0);
      chk("rst.hold.r",     int'(o_r), 0);
      chk("rst.hold.i",     int'(o_i), 0);
      @(posedge clk);
      #1;
      rst = 1'b0;

      // ---------------- start on the completion cycle ----------------
      step(1, 1, 1, 1, 1);
      step(0, 1, 1, 1, 1);
      step(0, 1, 1, 1, 1);
      step(1, 1, 1, 1, 1);
      chk_out("startdone.result", 1, 4, 4, 1, 0);
      step(0, 1, 2, 2, 1);
      step(0, 1, 2, 2, 1);
      step(0, 1, 2, 2, 1);
      chk_out("startdone.empty_start", 0, 0, 0, 1, 0);
      step(0, 1, 2, 2, 1);
      chk_out("startdone.next", 1, 8, 8, 0, 0);
      step(0, 0, 0, 0, 1);

      // ---------------- completion on a handshake cycle ----------------
      step(1, 1, 1, 1, 0);
      repeat (3) step(0, 1, 1, 1, 0);
      chk_out("hs.A", 1, 4, 4, 0, 0);
      step(1, 1, 6, -6, 0);
      step(0, 1, 6, -6, 0);
      step(0, 1, 6, -6, 0);
      step(0, 1, 6, -6, 1);
      chk_out("hs.B_loaded", 1, 24, -24, 0, 0);
      step(0, 0, 0, 0, 1);
      chk_out("hs.drained", 0, 0, 0, 0, 0);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule : tb_comp_acc
`default_nettype wire
